// File: rtl/jk_defs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : jk_defs                                                       |
// | Brief    : JK cell mode encodings and parameter range helper.            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package jk_defs;

  // Cell modes, encoded as {j, k}
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  function automatic bit max_count_ok(input int width, input int max_count);
    return (width >= 1) && (width <= 16) &&
           (max_count > 0) && (max_count <= ((1 << width) - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jk_cell                                                       |
// | Brief    : Single-bit JK flip-flop with asynchronous active-high reset.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module jk_cell
  import jk_defs::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qnot
);

  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD:   r_q <= r_q;
        JK_RESET:  r_q <= 1'b0;
        JK_SET:    r_q <= 1'b1;
        JK_TOGGLE: r_q <= ~r_q;
        default:   r_q <= r_q;
      endcase
    end
  end

  assign q    = r_q;
  assign qnot = ~r_q;

endmodule
`default_nettype wire

// File: rtl/jk_mod_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jk_mod_counter                                                |
// | Brief    : Modulo up/down counter with load, built from JK cells.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module jk_mod_counter
  import jk_defs::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qnot,
  output logic             tc
);

  localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  if (!max_count_ok(WIDTH, MAX_COUNT)) begin : g_bad_param
    $error("jk_mod_counter: MAX_COUNT out of range for WIDTH");
  end

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qnot;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;

  always_comb begin
    w_next = w_q;
    if (load) begin
      w_next = (din > c_max) ? c_max : din;
    end else if (en) begin
      // An out-of-range state recovers to zero regardless of direction
      if (w_q > c_max) begin
        w_next = c_zero;
      end else if (up) begin
        w_next = (w_q == c_max) ? c_zero : (w_q + c_one);
      end else begin
        w_next = (w_q == c_zero) ? c_max : (w_q - c_one);
      end
    end
  end

  // Only set/reset/hold are ever requested: J and K are never both high
  assign w_j = w_next & ~w_q;
  assign w_k = ~w_next & w_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cells
    jk_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .j    (w_j[i]),
      .k    (w_k[i]),
      .q    (w_q[i]),
      .qnot (w_qnot[i])
    );
  end

  assign q    = w_q;
  assign qnot = w_qnot;
  assign tc   = en & ~load & ((up & (w_q == c_max)) | (~up & (w_q == c_zero)));

endmodule
`default_nettype wire

// File: tb/tb_jk_mod_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_jk_mod_counter                                             |
// | Brief    : Directed self-checking bench for jk_mod_counter (4 bits, 9).  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] din;
  logic [3:0] q, qnot;
  logic       tc;

  logic       rst_c, en_c;
  logic [3:0] q_lo, q_hi, qnot_lo, qnot_hi;
  logic       tc_lo, tc_hi;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MAX_COUNT(9)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q), .qnot(qnot), .tc(tc)
  );

  jk_mod_counter #(.WIDTH(4), .MAX_COUNT(9)) u_lo (
    .clk(clk), .rst(rst_c), .en(en_c), .up(1'b1), .load(1'b0), .din(4'd0),
    .q(q_lo), .qnot(qnot_lo), .tc(tc_lo)
  );

  jk_mod_counter #(.WIDTH(4), .MAX_COUNT(9)) u_hi (
    .clk(clk), .rst(rst_c), .en(tc_lo), .up(1'b1), .load(1'b0), .din(4'd0),
    .q(q_hi), .qnot(qnot_hi), .tc(tc_hi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0;
    tick(); tick();
    checks++;
    if (q !== 4'd0 || qnot !== 4'hF || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset: q=%0d qnot=%h tc=%b, want q=0 qnot=f tc=0", q, qnot, tc);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (q !== 4'd0 || qnot !== 4'hF) begin
        errors++;
        $display("FAIL hold_after_reset[%0d]: q=%0d qnot=%h, want q=0 qnot=f", i, q, qnot);
      end
    end
  endtask

  task automatic test_count_up();
    logic [3:0] exp_q [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic [3:0] prev = 4'd0;
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (tc !== (prev == 4'd9)) begin
        errors++;
        $display("FAIL up_tc[%0d]: tc=%b at q=%0d, want %b", i, tc, q, prev == 4'd9);
      end
      tick();
      checks++;
      if (q !== exp_q[i] || qnot !== ~exp_q[i]) begin
        errors++;
        $display("FAIL up_q[%0d]: q=%0d qnot=%h, want q=%0d", i, q, qnot, exp_q[i]);
      end
      prev = exp_q[i];
    end
  endtask

  task automatic test_count_down();
    logic [3:0] exp_q [3] = '{4'd9, 4'd8, 4'd7};
    load = 1'b1; din = 4'd0; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tc !== (i == 0)) begin
        errors++;
        $display("FAIL down_tc[%0d]: tc=%b at q=%0d, want %b", i, tc, q, i == 0);
      end
      tick();
      checks++;
      if (q !== exp_q[i]) begin
        errors++;
        $display("FAIL down_q[%0d]: q=%0d, want %0d", i, q, exp_q[i]);
      end
    end
    up = 1'b1;
    tick();
    checks++;
    if (q !== 4'd8) begin
      errors++;
      $display("FAIL dir_change: q=%0d, want 8", q);
    end
  endtask

  task automatic test_load();
    load = 1'b1; din = 4'd0; en = 1'b0;
    tick();
    // At q=0 counting down, tc would be high were load not asserted
    en = 1'b1; up = 1'b0; din = 4'd5;
    #1;
    checks++;
    if (tc !== 1'b0) begin
      errors++;
      $display("FAIL load_tc: tc=%b, want 0", tc);
    end
    tick();
    checks++;
    if (q !== 4'd5) begin
      errors++;
      $display("FAIL load_5: q=%0d, want 5", q);
    end
    din = 4'd13;
    tick();
    checks++;
    if (q !== 4'd9) begin
      errors++;
      $display("FAIL load_clamp: q=%0d, want 9", q);
    end
    load = 1'b0; en = 1'b0;
    tick();
    checks++;
    if (q !== 4'd9) begin
      errors++;
      $display("FAIL hold_after_load: q=%0d, want 9", q);
    end
  endtask

  task automatic test_async_reset();
    load = 1'b1; din = 4'd0; en = 1'b1; up = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (q !== 4'd6) begin
      errors++;
      $display("FAIL pre_reset: q=%0d, want 6", q);
    end
    load = 1'b1; din = 4'd8;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 4'd0 || qnot !== 4'hF) begin
      errors++;
      $display("FAIL async_reset: q=%0d qnot=%h, want q=0 qnot=f", q, qnot);
    end
    #1 rst = 1'b0; din = 4'd3;
    tick();
    checks++;
    if (q !== 4'd3) begin
      errors++;
      $display("FAIL load_after_reset: q=%0d, want 3", q);
    end
    load = 1'b0;
  endtask

  task automatic test_cascade();
    rst_c = 1'b1; en_c = 1'b0;
    tick();
    rst_c = 1'b0; en_c = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    checks++;
    if (q_hi !== 4'd2 || q_lo !== 4'd5) begin
      errors++;
      $display("FAIL cascade: hi=%0d lo=%0d, want hi=2 lo=5", q_hi, q_lo);
    end
    checks++;
    if (tc_lo !== 1'b0 || tc_hi !== 1'b0) begin
      errors++;
      $display("FAIL cascade_tc: tc_lo=%b tc_hi=%b, want 0 0", tc_lo, tc_hi);
    end
  endtask

  initial begin
    rst_c = 1'b1; en_c = 1'b0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_async_reset();
    test_cascade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
